prog_dumper: RTL and testbench
==============================

// Module: prog_dumper
// PURPOSE
//  Readback counterpart of the UART program loader.
//  Reads `length` bytes from the 21-bit external memory bus, starting at address 0, on request.
//  Streams each byte out over UART TX as 8N1, LSB first.
//  Runs on the fast UART clock domain while the CPU is held in reset, and shares the
//  adr/read bus that the loader drives.
// PARAMETERS
//  CLK_DIV    104  clk cycles per UART bit (12 MHz / 115200); must be >= 2
//  READ_WAIT  2    cycles `read` is held before `din` is sampled; must be >= 1
// PORTS
//  clk     in   1   UART/system clock; all state changes on posedge
//  reset   in   1   synchronous, active-high
//  start   in   1   begin dump; sampled only in IDLE
//  length  in   21  byte count; latched on accepted start
//  adr     out  21  memory address of current byte
//  read    out  1   memory read strobe
//  din     in   8   memory read data
//  tx      out  1   UART TX line, idle high
//  busy    out  1   high from accepted start until done
//  done    out  1   one-cycle pulse at end of dump
// BEHAVIOUR
//  Reset (any state, takes effect next edge): tx=1, read=0, adr=0, busy=0, done=0, state=IDLE.
//    Any frame in flight is abandoned.
//  IDLE, start=1 at edge k:
//    - len<=length, adr<=0, busy<=1, csum<=0.
//    - If length==0: go to FINISH.
//    - Else: read<=1, rcnt<=READ_WAIT-1, state READ.
//  READ: rcnt decrements each cycle. At rcnt==0:
//    - shreg<=din, csum<=csum+din (mod 256), read<=0.
//    - tx<=0 (start bit), bit=0, div<=CLK_DIV-1, state TX.
//  TX: each bit is held exactly CLK_DIV cycles.
//    - Order: start(0), d0..d7, stop(1). Frame = 10*CLK_DIV cycles.
//  End of stop bit:
//    - If adr+1==len: go to FINISH.
//    - Else: adr<=adr+1, read<=1, rcnt<=READ_WAIT-1, state READ.
//  Inter-byte gap: READ_WAIT cycles of tx=1.
//  FINISH: done<=1, busy<=0 for one cycle, then IDLE. adr keeps its last value.
//  start while busy: ignored. A start on the same edge that done is asserted is also ignored.
//  length may be up to 2^21-1. adr never wraps; the compare is exact 21-bit.
//  tx is registered, with no combinational path from any input to tx.
//  read is high only in READ.
// CONFIGURATION
//  PROG_DUMPER_CHECKSUM_EN defined:
//    - Before FINISH, one extra 8N1 frame carries csum = 8-bit sum of all sent bytes.
//    - For length==0 this frame is 0x00.
//    - No read cycle is issued for it, and adr is not incremented.
//  Undefined: no trailer frame; csum logic is absent.
// TESTING
//  1. Reset asserted mid-frame (CLK_DIV=4):
//     -> next cycle tx=1, read=0, busy=0, adr=0; no done pulse.
//  2. CLK_DIV=4, READ_WAIT=2, mem[0]=0x55, length=1, start:
//     -> read high 2 cycles, then tx = 0,1,0,1,0,1,0,1,0,1, each held 4 cycles;
//     -> done pulses exactly 1 cycle later.
//  3. length=3, mem={0xA0,0x0F,0xFF}:
//     -> adr 0,1,2 each with one read window; 3 frames with those bytes;
//     -> exactly one done pulse; busy high throughout.
//  4. length=0, start:
//     -> no read; tx stays 1 (checksum off); done 1 cycle after start.
//  5. start pulsed again during frame 2 of test 3:
//     -> ignored; byte count and adr sequence unchanged.
//  6. PROG_DUMPER_CHECKSUM_EN, mem={0x01,0x02,0xFF}, length=3:
//     -> 4th frame = 0x02, then done.

Source files
------------

// File: rtl/prog_dumper_if.sv
// rtl/prog_dumper_if.sv - request, memory-read and UART TX signals of the program dumper
interface prog_dumper_if;
  logic        start;
  logic [20:0] length;
  logic [20:0] adr;
  logic        read;
  logic [7:0]  din;
  logic        tx;
  logic        busy;
  logic        done;

  modport master (
    input  start, length, din,
    output adr, read, tx, busy, done
  );

  modport slave (
    output start, length, din,
    input  adr, read, tx, busy, done
  );
endinterface

// File: rtl/prog_dumper.sv
// rtl/prog_dumper.sv - reads length bytes from address 0 and sends each as a UART 8N1 frame
// Optional PROG_DUMPER_CHECKSUM_EN appends a frame carrying the 8-bit sum of all sent bytes.
module prog_dumper #(
  parameter int CLK_DIV   = 104,
  parameter int READ_WAIT = 2
) (
  input logic          clk,
  input logic          reset,
  prog_dumper_if.master bus
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int RW_W  = (READ_WAIT > 1) ? $clog2(READ_WAIT) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [RW_W-1:0]  RW_LAST  = RW_W'(READ_WAIT - 1);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_TX, S_FINISH} state_t;

  state_t           state_q, state_d;
  logic [20:0]      len_q, len_d;
  logic [20:0]      adr_q, adr_d;
  logic             read_q, read_d;
  logic [RW_W-1:0]  rcnt_q, rcnt_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             tx_q, tx_d;
  logic [3:0]       bitc_q, bitc_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
`ifdef PROG_DUMPER_CHECKSUM_EN
  logic [7:0]       csum_q, csum_d;
  logic             trailer_q, trailer_d;
`endif

  assign bus.adr  = adr_q;
  assign bus.read = read_q;
  assign bus.tx   = tx_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      len_q     <= '0;
      adr_q     <= '0;
      read_q    <= 1'b0;
      rcnt_q    <= '0;
      shreg_q   <= '0;
      tx_q      <= 1'b1;
      bitc_q    <= '0;
      div_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef PROG_DUMPER_CHECKSUM_EN
      csum_q    <= '0;
      trailer_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      adr_q     <= adr_d;
      read_q    <= read_d;
      rcnt_q    <= rcnt_d;
      shreg_q   <= shreg_d;
      tx_q      <= tx_d;
      bitc_q    <= bitc_d;
      div_q     <= div_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef PROG_DUMPER_CHECKSUM_EN
      csum_q    <= csum_d;
      trailer_q <= trailer_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    adr_d     = adr_q;
    read_d    = read_q;
    rcnt_d    = rcnt_q;
    shreg_d   = shreg_q;
    tx_d      = tx_q;
    bitc_d    = bitc_q;
    div_d     = div_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
`ifdef PROG_DUMPER_CHECKSUM_EN
    csum_d    = csum_q;
    trailer_d = trailer_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          len_d  = bus.length;
          adr_d  = '0;
          busy_d = 1'b1;
`ifdef PROG_DUMPER_CHECKSUM_EN
          csum_d    = '0;
          trailer_d = 1'b0;
`endif
          if (bus.length == 21'd0) begin
`ifdef PROG_DUMPER_CHECKSUM_EN
            // Empty dump still sends the (zero) checksum frame.
            trailer_d = 1'b1;
            shreg_d   = 8'h00;
            tx_d      = 1'b0;
            bitc_d    = '0;
            div_d     = DIV_LAST;
            state_d   = S_TX;
`else
            state_d   = S_FINISH;
`endif
          end else begin
            read_d  = 1'b1;
            rcnt_d  = RW_LAST;
            state_d = S_READ;
          end
        end
      end

      S_READ: begin
        if (rcnt_q == '0) begin
          shreg_d = bus.din;
`ifdef PROG_DUMPER_CHECKSUM_EN
          csum_d  = csum_q + bus.din;
`endif
          read_d  = 1'b0;
          tx_d    = 1'b0;
          bitc_d  = '0;
          div_d   = DIV_LAST;
          state_d = S_TX;
        end else begin
          rcnt_d = rcnt_q - RW_W'(1);
        end
      end

      S_TX: begin
        if (div_q != '0) begin
          div_d = div_q - DIV_W'(1);
        end else if (bitc_q != 4'd9) begin
          // Bit slot n+1 carries data bit n; slot 9 is the stop bit.
          bitc_d = bitc_q + 4'd1;
          div_d  = DIV_LAST;
          tx_d   = (bitc_q == 4'd8) ? 1'b1 : shreg_q[bitc_q[2:0]];
        end else begin
`ifdef PROG_DUMPER_CHECKSUM_EN
          if (trailer_q) begin
            state_d = S_FINISH;
          end else if (adr_q + 21'd1 == len_q) begin
            trailer_d = 1'b1;
            shreg_d   = csum_q;
            tx_d      = 1'b0;
            bitc_d    = '0;
            div_d     = DIV_LAST;
          end else begin
            adr_d   = adr_q + 21'd1;
            read_d  = 1'b1;
            rcnt_d  = RW_LAST;
            state_d = S_READ;
          end
`else
          if (adr_q + 21'd1 == len_q) begin
            state_d = S_FINISH;
          end else begin
            adr_d   = adr_q + 21'd1;
            read_d  = 1'b1;
            rcnt_d  = RW_LAST;
            state_d = S_READ;
          end
`endif
        end
      end

      S_FINISH: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
`ifdef PROG_DUMPER_CHECKSUM_EN
        trailer_d = 1'b0;
`endif
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_prog_dumper.sv
// tb/tb_prog_dumper.sv - directed vector bench for prog_dumper (CLK_DIV=4, READ_WAIT=2)
module tb_prog_dumper;

  localparam int CD = 4;
  localparam int RW = 2;
  localparam int BUDGET = 1000;
`ifdef PROG_DUMPER_CHECKSUM_EN
  localparam int CKS = 1;
`else
  localparam int CKS = 0;
`endif

  typedef struct {
    logic [20:0] len;
    logic [31:0] mem;
    logic [31:0] exp_b;
    int          inj;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  logic [7:0] mem [16];
  bit tx_hist [$];
  int n_vec = 0;
  int n_fail = 0;

  prog_dumper_if bus ();

  prog_dumper #(.CLK_DIV(CD), .READ_WAIT(RW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  assign bus.din = mem[bus.adr[3:0]];

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic load_mem(input logic [31:0] m);
    for (int j = 0; j < 16; j++) mem[j] = (j < 4) ? m[8*j +: 8] : 8'h00;
  endtask

  task automatic run_dump(input int vid, input logic [20:0] len, input logic [31:0] exp_b, input int inj);
    int done_idx, done_cnt, busy_bad, rd_win, rd_bad, adr_bad, run_len;
    int nf, last_end, frame_bad, gap_bad, i, exp_start, idx;
    logic prev_read, is_trl, ebit, fbad;
    logic [20:0] adr_done;
    logic [7:0] eb;
    done_idx = -1; done_cnt = 0; busy_bad = 0; rd_win = 0; rd_bad = 0; adr_bad = 0;
    run_len = 0; prev_read = 1'b0; adr_done = '0;
    tx_hist.delete();
    @(negedge clk);
    bus.length = len;
    bus.start  = 1'b1;
    @(negedge clk);
    bus.start  = 1'b0;
    for (int cyc = 0; cyc < BUDGET; cyc++) begin
      if (cyc > 0) @(negedge clk);
      bus.start = (inj != 0 && cyc == inj);
      if (inj != 0 && cyc == inj) bus.length = 21'd1;
      tx_hist.push_back(bus.tx);
      if (bus.read) begin
        if (!prev_read) begin rd_win++; run_len = 0; end
        run_len++;
        if (bus.adr !== 21'(rd_win - 1)) adr_bad++;
      end else if (prev_read && run_len != RW) begin
        rd_bad++;
      end
      prev_read = bus.read;
      if (bus.done) begin
        done_cnt++;
        if (done_idx < 0) begin done_idx = cyc; adr_done = bus.adr; end
      end
      if (bus.busy !== (done_idx < 0)) busy_bad++;
      if (done_idx >= 0 && cyc >= done_idx + 3) break;
    end
    bus.start = 1'b0;
    check($sformatf("v%0d_done_seen", vid), 32'(done_idx >= 0), 32'd1);

    nf = 0; last_end = 0; frame_bad = 0; gap_bad = 0; i = 0;
    while (i < tx_hist.size()) begin
      if (tx_hist[i] == 1'b0) begin
        is_trl = (CKS == 1) && (nf == int'(len));
        exp_start = ((nf == 0) ? 0 : last_end) + (is_trl ? 0 : RW);
        if (i != exp_start) gap_bad++;
        eb = (nf < 4) ? exp_b[8*nf +: 8] : 8'hxx;
        fbad = 1'b0;
        for (int b = 0; b < 10; b++) begin
          ebit = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : eb[b-1];
          for (int c = 0; c < CD; c++) begin
            idx = i + b*CD + c;
            if (idx >= tx_hist.size() || tx_hist[idx] !== ebit) fbad = 1'b1;
          end
        end
        if (fbad) frame_bad++;
        nf++;
        last_end = i + 10*CD;
        i = last_end;
      end else begin
        i++;
      end
    end
    check($sformatf("v%0d_frames", vid), 32'(nf), 32'(int'(len) + CKS));
    check($sformatf("v%0d_frame_bits", vid), 32'(frame_bad), 32'd0);
    check($sformatf("v%0d_gaps", vid), 32'(gap_bad), 32'd0);
    check($sformatf("v%0d_done_time", vid), 32'(done_idx), 32'((nf > 0) ? last_end + 1 : 1));
    check($sformatf("v%0d_done_pulses", vid), 32'(done_cnt), 32'd1);
    check($sformatf("v%0d_busy", vid), 32'(busy_bad), 32'd0);
    check($sformatf("v%0d_read_windows", vid), 32'(rd_win), 32'(len));
    check($sformatf("v%0d_read_len", vid), 32'(rd_bad), 32'd0);
    check($sformatf("v%0d_read_adr", vid), 32'(adr_bad), 32'd0);
    check($sformatf("v%0d_adr_final", vid), 32'(adr_done), 32'((len > 0) ? len - 21'd1 : 21'd0));
  endtask

  initial begin
    vec_t vecs [6];
    int dcnt, tx_low;
    vecs[0] = '{21'd1, 32'h0000_0055, 32'h0000_5555, 0};
    vecs[1] = '{21'd3, 32'h00FF_0FA0, 32'hAEFF_0FA0, 0};
    vecs[2] = '{21'd0, 32'h0000_0000, 32'h0000_0000, 0};
    vecs[3] = '{21'd3, 32'h00FF_0201, 32'h02FF_0201, 0};
    vecs[4] = '{21'd3, 32'h00FF_0FA0, 32'hAEFF_0FA0, 60};
    vecs[5] = '{21'd2, 32'h0000_8000, 32'h0080_8000, 0};

    reset = 1'b1;
    bus.start = 1'b0;
    bus.length = '0;
    load_mem(32'h0);
    repeat (3) @(negedge clk);
    check("reset_tx", 32'(bus.tx), 32'd1);
    check("reset_read", 32'(bus.read), 32'd0);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_adr", 32'(bus.adr), 32'd0);
    reset = 1'b0;

    for (int k = 0; k < 6; k++) begin
      load_mem(vecs[k].mem);
      run_dump(k, vecs[k].len, vecs[k].exp_b, vecs[k].inj);
      repeat (3) @(negedge clk);
    end

    // Reset during the second frame abandons it cleanly.
    load_mem(32'h00FF_0FA0);
    @(negedge clk);
    bus.length = 21'd3;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (59) @(negedge clk);
    check("midframe_adr_pre", 32'(bus.adr), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midreset_tx", 32'(bus.tx), 32'd1);
    check("midreset_read", 32'(bus.read), 32'd0);
    check("midreset_busy", 32'(bus.busy), 32'd0);
    check("midreset_adr", 32'(bus.adr), 32'd0);
    dcnt = 0; tx_low = 0;
    repeat (100) begin
      @(negedge clk);
      if (bus.done) dcnt++;
      if (!bus.tx) tx_low++;
    end
    check("midreset_no_done", 32'(dcnt), 32'd0);
    check("midreset_tx_idle", 32'(tx_low), 32'd0);

    // Start held across the finishing edge yields exactly one dump.
    @(negedge clk);
    bus.length = 21'd0;
    bus.start = 1'b1;
    repeat (2) @(negedge clk);
    bus.start = 1'b0;
    dcnt = (bus.done === 1'b1) ? 1 : 0;
    repeat (60) begin
      @(negedge clk);
      if (bus.done) dcnt++;
    end
    check("held_start_done_pulses", 32'(dcnt), 32'd1);
    check("held_start_busy_end", 32'(bus.busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
